// File: rtl/i2s_slave_rx.sv
// Slave I2S receiver: oversampled sclk/ws/sd deserialized into a show-ahead FIFO.
// Define I2S_RX_SIGN_EXT_EN to sign-extend pushed words from bit N-1.
module i2s_slave_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic                               sclk_i,
    input  logic                               ws_i,
    input  logic                               sd_i,
    input  logic                               rx_en,
    input  logic [1:0]                         standard,
    input  logic [1:0]                         frame_size,
    input  logic                               stereo,
    input  logic                               rd_en,
    input  logic                               ovr_clr,
    output logic [31:0]                        rd_data,
    output logic                               rd_ch,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic                               overrun,
    output logic                               frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_WS = 2'd1;
    localparam logic [1:0] RECV    = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sy, ws_sy, sd_sy;
    logic                   sclk_d, ws_prev, wsr, cur_ch, st_l;
    logic [1:0]             state, std_l, fs_l;
    logic [5:0]             bitcnt, n_l, shamt;
    logic [31:0]            sr, mask, raw, word;
    logic                   sclk_s, ws_s, sd_s, se, lsb_l, wsr_nx;
    logic                   bnd, short_slot, push, do_push, do_pop;
    logic [32:0]            mem [FIFO_DEPTH];
    logic [32:0]            head;
    logic [AW-1:0]          wptr, rptr;
    logic [LW-1:0]          count;

    assign sclk_s = sclk_sy[SYNC_STAGES-1];
    assign ws_s   = ws_sy[SYNC_STAGES-1];
    assign sd_s   = sd_sy[SYNC_STAGES-1];
    assign se     = sclk_s & ~sclk_d;
    assign lsb_l  = (std_l == 2'd2);

    // Philips uses ws one bit late so the boundary lands on the MSB
    assign wsr_nx = (std_l == 2'd0) ? ws_prev : ws_s;
    assign bnd    = se && (wsr_nx != wsr);

    assign n_l        = {1'b0, fs_l, 3'b000} + 6'd8;
    assign short_slot = (bitcnt < n_l);
    assign shamt      = n_l - bitcnt;

    always_comb begin
        mask = 32'h0000_00ff;
        unique case (fs_l)
            2'd0:    mask = 32'h0000_00ff;
            2'd1:    mask = 32'h0000_ffff;
            2'd2:    mask = 32'h00ff_ffff;
            default: mask = 32'hffff_ffff;
        endcase
    end

    assign raw = (lsb_l || !short_slot) ? sr : (sr << shamt);

`ifdef I2S_RX_SIGN_EXT_EN
    logic sign;
    assign sign = |(raw & mask & ~(mask >> 1));
    assign word = (raw & mask) | ({32{sign}} & ~mask);
`else
    assign word = raw & mask;
`endif

    assign push = (state == RECV) && rx_en && bnd && (!cur_ch || st_l);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            sclk_sy <= '0;
            ws_sy   <= '0;
            sd_sy   <= '0;
            sclk_d  <= 1'b0;
        end else begin
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_i};
            ws_sy   <= {ws_sy[SYNC_STAGES-2:0], ws_i};
            sd_sy   <= {sd_sy[SYNC_STAGES-2:0], sd_i};
            sclk_d  <= sclk_s;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
        end else if (!rx_en) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    state <= WAIT_WS;
                WAIT_WS: if (bnd) state <= RECV;
                default: state <= RECV;
            endcase
        end
    end

    // Config is frozen per slot while receiving
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            std_l <= 2'd0;
            fs_l  <= 2'd0;
            st_l  <= 1'b0;
        end else if (state != RECV || bnd) begin
            std_l <= standard;
            fs_l  <= frame_size;
            st_l  <= stereo;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            ws_prev <= 1'b0;
            wsr     <= 1'b0;
            cur_ch  <= 1'b0;
            bitcnt  <= 6'd0;
            sr      <= 32'd0;
        end else if (se) begin
            ws_prev <= ws_s;
            wsr     <= wsr_nx;
            if (bnd) begin
                cur_ch <= wsr_nx;
                bitcnt <= 6'd1;
                sr     <= {31'd0, sd_s};
            end else begin
                if (bitcnt != 6'd63) bitcnt <= bitcnt + 6'd1;
                if (lsb_l || short_slot) sr <= {sr[30:0], sd_s};
            end
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) frame_err <= 1'b0;
        else         frame_err <= push && short_slot;
    end

    assign empty   = (count == '0);
    assign full    = (count == LW'(FIFO_DEPTH));
    assign level   = count;
    assign do_pop  = rd_en && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];
    assign rd_data = empty ? 32'd0 : head[31:0];
    assign rd_ch   = empty ? 1'b0 : head[32];

    always_ff @(posedge pclk) begin
        if (do_push) mem[wptr] <= {cur_ch, word};
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (push && full && !do_pop) overrun <= 1'b1;
            else if (ovr_clr)            overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_i2s_slave_rx.sv
// Bench for i2s_slave_rx: drives I2S slot streams, compares FIFO against a slot-level model.
// Honours I2S_RX_SIGN_EXT_EN in the expected words.
module tb_i2s_slave_rx;
    logic        pclk = 1'b0;
    logic        preset, sclk_i, ws_i, sd_i, rx_en, stereo, rd_en, ovr_clr;
    logic [1:0]  standard, frame_size;
    logic [31:0] rd_data;
    logic        rd_ch, empty, full, overrun, frame_err;
    logic [3:0]  level;

    i2s_slave_rx #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset(preset), .sclk_i(sclk_i), .ws_i(ws_i),
        .sd_i(sd_i), .rx_en(rx_en), .standard(standard),
        .frame_size(frame_size), .stereo(stereo), .rd_en(rd_en),
        .ovr_clr(ovr_clr), .rd_data(rd_data), .rd_ch(rd_ch),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;
    int fe_cnt = 0;

    always @(negedge pclk) if (frame_err === 1'b1) fe_cnt++;

    logic [32:0] mq[$];
    bit          m_ov = 1'b0;
    int          m_fe = 0;
    bit          s_ch[$];
    int          s_len[$];
    logic [63:0] s_bits[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] std,
            input logic [1:0] fs, input int len, input logic [63:0] bits);
        int n;
        logic [63:0] v, m;
        n = (int'(fs) + 1) * 8;
        m = (64'd1 << n) - 64'd1;
        if (std == 2'd2)   v = bits & m;
        else if (len >= n) v = (bits >> (len - n)) & m;
        else               v = (bits << (n - len)) & m;
`ifdef I2S_RX_SIGN_EXT_EN
        if (v[n-1]) v = v | ~m;
`endif
        return v[31:0];
    endfunction

    task automatic add_slot(input bit ch, input int len, input logic [63:0] bits);
        s_ch.push_back(ch);
        s_len.push_back(len);
        s_bits.push_back(bits & ((64'd1 << len) - 64'd1));
    endtask

    task automatic play(input int abort_at);
        bit wq[$];
        bit dq[$];
        bit lc;
        int n;
        lc = !s_ch[0];
        for (int b = 0; b < 8; b++) begin
            wq.push_back(lc);
            dq.push_back(1'($urandom_range(0, 1)));
        end
        foreach (s_ch[k]) begin
            for (int b = s_len[k] - 1; b >= 0; b--) begin
                wq.push_back(s_ch[k]);
                dq.push_back(s_bits[k][b]);
            end
        end
        lc = !s_ch[s_ch.size()-1];
        for (int b = 0; b < 6; b++) begin
            wq.push_back(lc);
            dq.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < wq.size(); i++) begin
            if (i == 4) rx_en = 1'b1;
            if (i == abort_at) rx_en = 1'b0;
            ws_i = (standard == 2'd0 && i + 1 < wq.size()) ? wq[i+1] : wq[i];
            sd_i = dq[i];
            repeat (4) @(negedge pclk);
            sclk_i = 1'b1;
            repeat (4) @(negedge pclk);
            sclk_i = 1'b0;
        end
        repeat (12) @(negedge pclk);
        rx_en = 1'b0;
        repeat (2) @(negedge pclk);
        if (abort_at < 0) begin
            n = (int'(frame_size) + 1) * 8;
            foreach (s_ch[k]) begin
                if (s_ch[k] == 1'b0 || stereo) begin
                    if (mq.size() < 8)
                        mq.push_back({s_ch[k],
                            model_word(standard, frame_size, s_len[k], s_bits[k])});
                    else
                        m_ov = 1'b1;
                    if (s_len[k] < n) m_fe++;
                end
            end
        end
        s_ch.delete();
        s_len.delete();
        s_bits.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".level"}, 64'(level), 64'(mq.size()));
        chk({tag, ".full"}, 64'(full), 64'(mq.size() == 8));
        chk({tag, ".overrun"}, 64'(overrun), 64'(m_ov));
        chk({tag, ".ferr"}, 64'(fe_cnt), 64'(m_fe));
    endtask

    task automatic pop_all(input string tag);
        logic [32:0] e;
        while (mq.size() > 0) begin
            e = mq.pop_front();
            chk({tag, ".empty"}, 64'(empty), 64'd0);
            chk({tag, ".data"}, 64'(rd_data), 64'(e[31:0]));
            chk({tag, ".ch"}, 64'(rd_ch), 64'(e[32]));
            rd_en = 1'b1;
            @(negedge pclk);
            rd_en = 1'b0;
        end
        chk({tag, ".drained"}, 64'(empty), 64'd1);
    endtask

    task automatic cfg(input logic [1:0] std, input logic [1:0] fs, input logic st);
        standard = std;
        frame_size = fs;
        stereo = st;
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        preset = 1'b0; sclk_i = 1'b0; ws_i = 1'b0; sd_i = 1'b0;
        rx_en = 1'b0; standard = 2'd1; frame_size = 2'd1; stereo = 1'b1;
        rd_en = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst.empty", 64'(empty), 64'd1);
        chk("rst.full", 64'(full), 64'd0);
        chk("rst.level", 64'(level), 64'd0);
        chk("rst.overrun", 64'(overrun), 64'd0);
        chk("rst.ferr", 64'(frame_err), 64'd0);
        chk("rst.data", 64'(rd_data), 64'd0);
        chk("rst.ch", 64'(rd_ch), 64'd0);
        preset = 1'b1;
        repeat (2) @(negedge pclk);

        cfg(2'd1, 2'd1, 1'b1);
        add_slot(1'b0, 16, 64'hA5C3);
        add_slot(1'b1, 16, 64'h1234);
        play(-1);
        check_state("msb");
        pop_all("msb");

        cfg(2'd0, 2'd2, 1'b1);
        add_slot(1'b0, 32, {32'd0, 24'h800001, 8'($urandom)});
        add_slot(1'b1, 32, 64'($urandom));
        play(-1);
        check_state("phil");
        pop_all("phil");

        cfg(2'd2, 2'd1, 1'b1);
        add_slot(1'b0, 32, 64'hFFFF_BEEF);
        add_slot(1'b1, 32, 64'hFFFF_BEEF);
        play(-1);
        check_state("lsb");
        pop_all("lsb");

        cfg(2'd1, 2'd2, 1'b0);
        add_slot(1'b0, 16, 64'hFFFF);
        add_slot(1'b1, 16, 64'($urandom));
        play(-1);
        check_state("short");
        pop_all("short");

        for (int r = 0; r < 6; r++) begin
            cfg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
            for (int k = 0; k < 4; k++)
                add_slot(1'(k % 2), $urandom_range(4, 40), {$urandom, $urandom});
            play(-1);
            check_state("rand");
            pop_all("rand");
        end

        cfg(2'd1, 2'd0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            add_slot(1'b0, 8, 64'(k));
            add_slot(1'b1, 8, 64'($urandom));
        end
        play(-1);
        check_state("mono");
        pop_all("mono");
        ovr_clr = 1'b1;
        @(negedge pclk);
        ovr_clr = 1'b0;
        m_ov = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);

        cfg(2'd1, 2'd1, 1'b1);
        add_slot(1'b0, 16, 64'($urandom));
        add_slot(1'b1, 16, 64'($urandom));
        play(16);
        check_state("abort");

        add_slot(1'b0, 16, 64'h5A5A);
        add_slot(1'b1, 16, 64'hC3C3);
        play(-1);
        check_state("pre_rst");
        rx_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ws_i = 1'b1;
            sd_i = 1'($urandom_range(0, 1));
            repeat (4) @(negedge pclk);
            sclk_i = 1'b1;
            repeat (4) @(negedge pclk);
            sclk_i = 1'b0;
        end
        #2 preset = 1'b0;
        #1;
        chk("arst.empty", 64'(empty), 64'd1);
        chk("arst.level", 64'(level), 64'd0);
        chk("arst.data", 64'(rd_data), 64'd0);
        chk("arst.ch", 64'(rd_ch), 64'd0);
        chk("arst.overrun", 64'(overrun), 64'd0);
        mq.delete();
        m_ov = 1'b0;
        rx_en = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        repeat (2) @(negedge pclk);

        cfg(2'd1, 2'd3, 1'b1);
        add_slot(1'b0, 32, 64'($urandom));
        add_slot(1'b1, 32, 64'($urandom));
        play(-1);
        check_state("post_rst");
        pop_all("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_slave_rx.md
Name: i2s_slave_rx

Overview:
- Slave-mode I2S receiver: the far end of the transceiver's master-transmit path.
- Accepts externally driven sclk/ws/sd, oversamples them on the APB clock, and deserializes per-channel words into a show-ahead FIFO.
- Supports Philips, MSB-justified and LSB-justified standards, 8/16/24/32-bit words, and stereo or mono.
- Sits beside the transceiver top as the receive endpoint; also used as a bench monitor.

Parameters:
- FIFO_DEPTH, 8, number of {channel, word} entries (power of 2, >=2).
- SYNC_STAGES, 2, flop stages on sclk_i/ws_i/sd_i (>=2).

Ports:
- pclk  in  1  system clock; must be >=4x sclk frequency.
- preset  in  1  asynchronous active-low reset.
- sclk_i  in  1  external bit clock (asynchronous).
- ws_i  in  1  external word select, 0=left, 1=right.
- sd_i  in  1  external serial data.
- rx_en  in  1  receive enable.
- standard  in  2  0=Philips, 1=MSB-justified, 2=LSB-justified, 3=reserved (treated as 1).
- frame_size  in  2  N: 0=8, 1=16, 2=24, 3=32 bits.
- stereo  in  1  1=push both channels, 0=push left only.
- rd_en  in  1  pop request.
- ovr_clr  in  1  clears overrun.
- rd_data  out  32  head word, right-aligned in [N-1:0].
- rd_ch  out  1  channel of head word.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH+1)  occupancy.
- overrun  out  1  sticky: word dropped due to full FIFO.
- frame_err  out  1  one-pclk pulse: slot shorter than N bits.

Behaviour:
- Reset (preset=0, async): FSM=IDLE, FIFO cleared; empty=1; full, level, overrun, frame_err, rd_data, rd_ch all 0.
- Sync and sampling:
  - sclk_i, ws_i, sd_i each pass through SYNC_STAGES flops.
  - Sample event (SE) = 0->1 transition of synchronized sclk; ws and sd are captured on the SE cycle.
- Slot-boundary reference wsr, updated on SE:
  - Philips: wsr = ws delayed one SE, so the MSB lands one bit after the ws edge.
  - MSB/LSB-justified: wsr = ws.
  - A boundary is an SE on which wsr differs from its previous value.
- FSM:
  - IDLE: wait for rx_en=1 -> WAIT_WS.
  - WAIT_WS: discard bits until the first boundary -> RECV. The partial first slot is never pushed.
  - RECV: at each boundary, close the current slot and open the new one with channel=new wsr.
  - rx_en=0 in any state -> IDLE next cycle. The in-progress word is discarded; FIFO contents are kept.
- Slot capture:
  - bitcnt counts SEs in the slot, saturating at 63.
  - Philips/MSB: the first N bits are shifted in MSB first; later bits are ignored.
  - LSB-justified: every bit shifts into a 32-bit register; the word is the last N bits before the boundary.
  - The bit sampled on the boundary SE belongs to the new slot.
- Slot close:
  - Word is committed to the FIFO on the cycle after the boundary SE; empty falls on that same cycle.
  - If bitcnt<N: frame_err pulses for one cycle and the word is still pushed. Philips/MSB pad the missing LSBs with 0; LSB-justified leaves the missing upper bits at 0.
  - stereo=0: right-channel slots are closed without a push and never raise frame_err.
- FIFO (first-word-fall-through):
  - rd_data/rd_ch are valid whenever empty=0.
  - rd_en with empty=0 pops; the next entry appears on the following cycle.
  - rd_en with empty=1 is ignored.
  - Push while full with no pop: word dropped, overrun set.
  - Push and pop in the same cycle while full: both succeed, level unchanged, no overrun.
  - Pointers wrap modulo FIFO_DEPTH; level is exact 0..FIFO_DEPTH.
- overrun: cleared only by ovr_clr=1 or reset. If ovr_clr and a drop occur in the same cycle, set wins.
- frame_size/standard/stereo changes take effect at the next boundary. The in-flight slot uses the values latched at its start.
- Bits [31:N] of rd_data are zero (see optional feature).

Optional Feature:
- Macro: I2S_RX_SIGN_EXT_EN.
- Defined: a pushed word has bits [31:N] replicated from bit N-1 (two's-complement audio).
- Undefined: bits [31:N] are zero; no sign logic is compiled.

Test Plan:
- Basic MSB-justified stereo: MSB, N=16, stereo, 16-bit slots; send L=0xA5C3, R=0x1234 -> FIFO gets (ch0,0x0000A5C3), (ch1,0x00001234); level=2; frame_err never pulses.
- Philips 24-bit: Philips, N=24, 32-bit slots; L=0x800001 -> rd_data=0x00800001 (0xFF800001 with I2S_RX_SIGN_EXT_EN); the bit on the ws edge is credited to the previous slot.
- LSB-justified: N=16, 32-bit slots, each slot's last 16 bits=0xBEEF, leading bits=1 -> rd_data=0x0000BEEF per channel.
- Mono + overrun: stereo=0, FIFO_DEPTH=8, 9 left words 1..9, no reads -> full=1, overrun=1, 9th word dropped, pops return 1..8; ovr_clr then clears overrun.
- Short slot: MSB, N=24, 16-bit slots, L=0xFFFF -> frame_err pulses, rd_data=0x00FFFF00.
- Abort and reset: rx_en=0 mid-slot -> no push, FSM=IDLE. Re-enable -> first partial slot discarded. preset=0 mid-slot -> all outputs 0, empty=1 without waiting for a pclk edge.
